mem_wb_stage: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM register and consumes its registered outputs.
- Contains the word-addressed data memory, variable-latency access control with a stall handshake, and branch-select generation.
- Contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_wb_pkg.sv | 37 +++
 rtl/mem_wb_stage_data_mem.sv | 38 +++
 rtl/mem_wb_stage.sv | 193 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_pkg
// Shared definitions for the MEM stage of the 5-stage MIPS pipeline.
//   - Bit positions inside the 2-bit write-back control bundle {regwrite, memtoreg}.
//   - Bit positions inside the 3-bit memory control bundle carried by EX/MEM
//     {branch, memread, memwrite}.
//   - Encoding of the memory-access state machine.
//   - A helper that classifies an access as bad (misaligned or read+write).
// -----------------------------------------------------------------------------
package mem_wb_pkg;

   // Write-back control bundle layout
   localparam int WB_W        = 2;
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // Memory control bundle layout, identical to the EX/MEM register
   localparam int M_W         = 3;
   localparam int M_BRANCH    = 2;
   localparam int M_MEMREAD   = 1;
   localparam int M_MEMWRITE  = 0;

   // Access state machine encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // An access is bad when it is not word aligned, or when it asks for a
   // load and a store at the same time. No access means nothing can be bad.
   function automatic logic is_bad_access(
      input logic       rd,
      input logic       wr,
      input logic [1:0] byte_lsb
   );
      return (rd | wr) & ((byte_lsb != 2'b00) | (rd & wr));
   endfunction

endpackage : mem_wb_pkg

// File: rtl/mem_wb_stage_data_mem.sv
// -----------------------------------------------------------------------------
// data_mem
// Word-addressed data memory for the MEM stage: DEPTH x 32 bits, single port,
// synchronous write, asynchronous (combinational) read.
//
// Ports
//   clk    in   1    clock, rising edge
//   we     in   1    write enable, sampled on the rising edge
//   addr   in   AW   word index, shared by read and write
//   wdata  in   32   write data
//   rdata  out  32   contents of mem[addr] before the next write edge
//
// Contents are not initialised; after power-up they are undefined.
// -----------------------------------------------------------------------------
module data_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   // Combinational read: a load in the same cycle as a committing edge sees
   // the pre-edge word.
   assign rdata = r_mem[addr];

endmodule : data_mem

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
// Memory-access stage of the 5-stage MIPS pipeline plus the MEM/WB register.
// Consumes the registered outputs of EX/MEM, performs loads and stores against
// the word-addressed data memory with a configurable per-access latency, raises
// a stall to freeze EX/MEM and everything upstream while an access is still in
// progress, and produces the branch select for fetch.
//
// Parameters
//   DEPTH    number of 32-bit data-memory words (power of 2)
//   MEM_LAT  cycles per load/store access (>= 1); 1 means no stall
//
// Ports
//   clk             in   1   clock, rising edge
//   reset           in   1   synchronous, active-high reset
//   ctlwb_in        in   2   write-back control {regwrite, memtoreg}
//   branch          in   1   branch instruction
//   memread         in   1   load
//   memwrite        in   1   store
//   add_result      in   32  branch target from EX
//   zero            in   1   ALU zero flag
//   alu_result      in   32  ALU result / byte address
//   rdata2          in   32  store data
//   dest_in         in   5   destination register
//   pcsrc           out  1   branch taken to fetch (combinational)
//   pc_target       out  32  branch target to fetch (combinational)
//   stall           out  1   hold EX/MEM and earlier stages this cycle
//   ctlwb_out       out  2   registered write-back control
//   read_data_out   out  32  registered load data
//   alu_result_out  out  32  registered ALU result
//   dest_out        out  5   registered destination register
//   mem_err         out  1   registered one-cycle pulse on a bad access
// -----------------------------------------------------------------------------
module mem_wb_stage
   import mem_wb_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WB_W-1:0]  ctlwb_in,
   input  logic             branch,
   input  logic             memread,
   input  logic             memwrite,
   input  logic [31:0]      add_result,
   input  logic             zero,
   input  logic [31:0]      alu_result,
   input  logic [31:0]      rdata2,
   input  logic [4:0]       dest_in,
   output logic             pcsrc,
   output logic [31:0]      pc_target,
   output logic             stall,
   output logic [WB_W-1:0]  ctlwb_out,
   output logic [31:0]      read_data_out,
   output logic [31:0]      alu_result_out,
   output logic [4:0]       dest_out,
   output logic             mem_err
);

   localparam int AW = $clog2(DEPTH);
   // Counter is at least one bit wide so the MEM_LAT=1 build stays legal.
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // -------------------------------------------------------------------------
   // Decode
   // -------------------------------------------------------------------------
   logic [M_W-1:0] w_m_ctl;
   logic           w_req;
   logic           w_bad;
   logic [AW-1:0]  w_idx;
   logic [CW-1:0]  w_cnt;
   logic           w_stall;
   logic           w_commit;
   logic           w_we;
   logic [31:0]    w_rdata;
   logic           w_unused;

   logic [0:0]     r_state;
   logic [CW-1:0]  r_cnt;
   logic [WB_W-1:0] r_ctlwb_out;
   logic [31:0]    r_read_data_out;
   logic [31:0]    r_alu_result_out;
   logic [4:0]     r_dest_out;
   logic           r_mem_err;

   assign w_m_ctl = {branch, memread, memwrite};
   assign w_req   = w_m_ctl[M_MEMREAD] | w_m_ctl[M_MEMWRITE];
   assign w_bad   = is_bad_access(w_m_ctl[M_MEMREAD], w_m_ctl[M_MEMWRITE],
                                  alu_result[1:0]);

   // Byte address to word index; address bits above the array wrap away.
   assign w_idx    = alu_result[AW+1:2];
   assign w_unused = ^alu_result[31:AW+2];

   // In IDLE every access starts from a fresh count regardless of what the
   // counter register holds.
   assign w_cnt = (r_state == ST_BUSY) ? r_cnt : '0;

   // The access is still in flight until its last latency cycle.
   assign w_stall  = w_req & (w_cnt != CNT_LAST);
   assign w_commit = w_req & ~w_stall;

   // A store commits only on its final cycle, only when well formed, and
   // never on a reset edge so that reset aborts an in-flight access.
   assign w_we = w_commit & w_m_ctl[M_MEMWRITE] & ~w_bad & ~reset;

   // -------------------------------------------------------------------------
   // Branch select: pure function of the EX/MEM outputs, independent of stall.
   // -------------------------------------------------------------------------
   assign pcsrc     = w_m_ctl[M_BRANCH] & zero;
   assign pc_target = add_result;
   assign stall     = w_stall;

   // -------------------------------------------------------------------------
   // Data memory
   // -------------------------------------------------------------------------
   data_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_data_mem (
      .clk   (clk),
      .we    (w_we),
      .addr  (w_idx),
      .wdata (rdata2),
      .rdata (w_rdata)
   );

   // -------------------------------------------------------------------------
   // Access FSM and latency counter
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else if (w_stall) begin
         r_state <= ST_BUSY;
         r_cnt   <= w_cnt + CNT_ONE;
      end else begin
         // Completion or no request: the next request starts from zero on
         // the very next cycle, so back-to-back accesses have no gap.
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end
   end

   // -------------------------------------------------------------------------
   // MEM/WB pipeline register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctlwb_out      <= '0;
         r_read_data_out  <= 32'd0;
         r_alu_result_out <= 32'd0;
         r_dest_out       <= 5'd0;
         r_mem_err        <= 1'b0;
      end else begin
         // Address and destination track their inputs every cycle; while
         // stalled upstream holds them, so they already match on completion.
         r_alu_result_out <= alu_result;
         r_dest_out       <= dest_in;

         if (w_stall) begin
            // Bubble into write-back while the access is still pending.
            r_ctlwb_out     <= '0;
            r_read_data_out <= 32'd0;
            r_mem_err       <= 1'b0;
         end else begin
            r_ctlwb_out[WB_REGWRITE] <= ctlwb_in[WB_REGWRITE];
            r_ctlwb_out[WB_MEMTOREG] <= ctlwb_in[WB_MEMTOREG];

            if (w_commit) begin
               // Load data is the pre-edge word; a bad access or a store
               // returns zero, and only a bad access raises the error pulse.
               r_read_data_out <= (w_m_ctl[M_MEMREAD] & ~w_bad) ? w_rdata : 32'd0;
               r_mem_err       <= w_bad;
            end else begin
               r_read_data_out <= 32'd0;
               r_mem_err       <= 1'b0;
            end
         end
      end
   end

   assign ctlwb_out      = r_ctlwb_out;
   assign read_data_out  = r_read_data_out;
   assign alu_result_out = r_alu_result_out;
   assign dest_out       = r_dest_out;
   assign mem_err        = r_mem_err;

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
// Runs one shared transaction stream (directed cases followed by random ones)
// through three instances of mem_wb_stage with MEM_LAT = 1, 2 and 3. Each
// instance has its own driver, its own transaction-level reference model
// (an associative word memory plus the access rules), an expectation queue
// and a monitor that compares whenever the stage completes a transaction.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

   localparam int DEPTH = 256;
   localparam int NINST = 3;
   localparam int NRAND = 200;

   typedef struct {
      logic [1:0]  ctl;
      logic        br;
      logic        zr;
      logic        mr;
      logic        mw;
      logic [31:0] add;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  dest;
      bit          rst_abort;
   } txn_t;

   typedef struct {
      logic [1:0]  ctl;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dest;
      logic        err;
      logic        pcs;
      logic [31:0] pct;
      int          nst;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   txn_t stim[$];

   function automatic void chk(input string name, input int lat,
                               input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s lat=%0d actual=%h required=%h", name, lat, act, req);
      end
   endfunction

   function automatic txn_t t_base();
      txn_t t;
      t.ctl = 2'b00; t.br = 1'b0; t.zr = 1'b0; t.mr = 1'b0; t.mw = 1'b0;
      t.add = 32'd0; t.alu = 32'd0; t.wd = 32'd0; t.dest = 5'd0;
      t.rst_abort = 1'b0;
      return t;
   endfunction

   function automatic txn_t t_sw(input logic [31:0] a, input logic [31:0] d);
      txn_t t = t_base();
      t.mw = 1'b1; t.alu = a; t.wd = d; t.dest = 5'd3;
      return t;
   endfunction

   function automatic txn_t t_lw(input logic [31:0] a, input logic [1:0] c);
      txn_t t = t_base();
      t.mr = 1'b1; t.alu = a; t.ctl = c; t.dest = 5'd9;
      return t;
   endfunction

   function automatic txn_t t_br(input logic z, input logic [31:0] target);
      txn_t t = t_base();
      t.br = 1'b1; t.zr = z; t.add = target; t.alu = 32'h0000_0004;
      return t;
   endfunction

   // ---------------------------------------------------------------------
   // Stimulus: fill the address pool, directed scenarios, then random.
   // ---------------------------------------------------------------------
   initial begin : build
      txn_t        t;
      int unsigned kind;
      logic [31:0] r;
      logic [31:0] a;
      for (int i = 0; i < 16; i++) stim.push_back(t_sw(32'(i * 4), $urandom));
      stim.push_back(t_sw(32'h10, 32'hDEADBEEF));
      stim.push_back(t_lw(32'h10, 2'b11));
      stim.push_back(t_br(1'b1, 32'h40));
      stim.push_back(t_br(1'b0, 32'h40));
      stim.push_back(t_sw(32'h13, 32'h12345678));
      stim.push_back(t_lw(32'h10, 2'b11));
      t = t_sw(32'h10, 32'h12345678);
      t.mr = 1'b1;
      stim.push_back(t);
      stim.push_back(t_lw(32'h10, 2'b10));
      stim.push_back(t_sw(32'h20, 32'h0));
      t = t_base();
      t.rst_abort = 1'b1;
      stim.push_back(t);
      stim.push_back(t_lw(32'h20, 2'b11));
      stim.push_back(t_sw(32'h20, 32'h11));
      stim.push_back(t_lw(32'h20, 2'b11));
      stim.push_back(t_sw(32'h0, 32'h1));
      stim.push_back(t_lw(32'h0, 2'b11));
      for (int i = 0; i < NRAND; i++) begin
         t      = t_base();
         t.ctl  = 2'($urandom_range(0, 3));
         t.br   = 1'($urandom_range(0, 1));
         t.zr   = 1'($urandom_range(0, 1));
         t.add  = $urandom;
         t.wd   = $urandom;
         t.dest = 5'($urandom_range(0, 31));
         r      = $urandom;
         a      = (r & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         t.alu  = a;
         kind   = $urandom_range(0, 9);
         if (kind >= 3 && kind <= 5) t.mr = 1'b1;
         if (kind >= 6 && kind <= 8) t.mw = 1'b1;
         if (kind == 9) begin t.mr = 1'b1; t.mw = 1'b1; end
         stim.push_back(t);
      end
   end

   // ---------------------------------------------------------------------
   // One DUT, driver, model and monitor per latency.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NINST; gi++) begin : g_lat
      localparam int LAT = gi + 1;

      logic        reset;
      logic [1:0]  ctlwb_in;
      logic        branch, memread, memwrite, zero;
      logic [31:0] add_result, alu_result, rdata2;
      logic [4:0]  dest_in;
      logic        pcsrc, stall, mem_err;
      logic [31:0] pc_target, read_data_out, alu_result_out;
      logic [1:0]  ctlwb_out;
      logic [4:0]  dest_out;

      bit          drv_valid = 1'b0;
      bit          done = 1'b0;
      int          stall_seen = 0;
      int          ntx = 0;
      exp_t        q[$];
      logic [31:0] mdl [int unsigned];

      mem_wb_stage #(
         .DEPTH   (DEPTH),
         .MEM_LAT (LAT)
      ) dut (
         .clk            (clk),
         .reset          (reset),
         .ctlwb_in       (ctlwb_in),
         .branch         (branch),
         .memread        (memread),
         .memwrite       (memwrite),
         .add_result     (add_result),
         .zero           (zero),
         .alu_result     (alu_result),
         .rdata2         (rdata2),
         .dest_in        (dest_in),
         .pcsrc          (pcsrc),
         .pc_target      (pc_target),
         .stall          (stall),
         .ctlwb_out      (ctlwb_out),
         .read_data_out  (read_data_out),
         .alu_result_out (alu_result_out),
         .dest_out       (dest_out),
         .mem_err        (mem_err)
      );

      initial begin : drv
         txn_t        t;
         exp_t        e;
         int          guard;
         int unsigned idx;
         logic        bad;
         reset = 1'b1;
         ctlwb_in = 2'b00; branch = 1'b0; zero = 1'b0; memread = 1'b0; memwrite = 1'b0;
         add_result = 32'd0; alu_result = 32'd0; rdata2 = 32'd0; dest_in = 5'd0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("rst_ctlwb", LAT, 32'(ctlwb_out), 32'd0);
         chk("rst_rdata", LAT, read_data_out, 32'd0);
         chk("rst_alu",   LAT, alu_result_out, 32'd0);
         chk("rst_dest",  LAT, 32'(dest_out), 32'd0);
         chk("rst_err",   LAT, 32'(mem_err), 32'd0);
         chk("rst_stall", LAT, 32'(stall), 32'd0);
         @(posedge clk); #2;
         reset = 1'b0;
         foreach (stim[k]) begin
            t = stim[k];
            if (t.rst_abort) begin
               if (LAT > 1) begin
                  // Start a store, then reset during its second cycle.
                  drv_valid = 1'b0;
                  ctlwb_in = 2'b11; branch = 1'b0; zero = 1'b0;
                  memread = 1'b0; memwrite = 1'b1; add_result = 32'd0;
                  alu_result = 32'h20; rdata2 = 32'hAAAA5555; dest_in = 5'd7;
                  @(posedge clk); #2;
                  reset = 1'b1;
                  @(posedge clk); #2;
                  reset = 1'b0;
                  ctlwb_in = 2'b00; memwrite = 1'b0; alu_result = 32'd0;
                  rdata2 = 32'd0; dest_in = 5'd0;
                  @(negedge clk);
                  chk("abort_ctlwb", LAT, 32'(ctlwb_out), 32'd0);
                  chk("abort_rdata", LAT, read_data_out, 32'd0);
                  chk("abort_alu",   LAT, alu_result_out, 32'd0);
                  chk("abort_dest",  LAT, 32'(dest_out), 32'd0);
                  chk("abort_err",   LAT, 32'(mem_err), 32'd0);
                  chk("abort_stall", LAT, 32'(stall), 32'd0);
                  @(posedge clk); #2;
               end
            end else begin
               ctlwb_in = t.ctl; branch = t.br; zero = t.zr;
               memread = t.mr; memwrite = t.mw; add_result = t.add;
               alu_result = t.alu; rdata2 = t.wd; dest_in = t.dest;
               // Reference model: rules applied to the whole transaction.
               bad   = (t.mr || t.mw) && ((t.alu % 4 != 0) || (t.mr && t.mw));
               idx   = (t.alu / 4) % DEPTH;
               e.ctl = t.ctl; e.alu = t.alu; e.dest = t.dest; e.err = bad;
               e.pcs = t.br && t.zr; e.pct = t.add;
               e.rd  = (t.mr && !bad) ? (mdl.exists(idx) ? mdl[idx] : 32'd0) : 32'd0;
               e.nst = (t.mr || t.mw) ? LAT - 1 : 0;
               if (t.mw && !bad) mdl[idx] = t.wd;
               q.push_back(e);
               drv_valid = 1'b1;
               guard = 0;
               do begin
                  @(negedge clk);
                  guard++;
               end while (stall && guard < LAT + 4);
               if (stall) begin
                  checks++;
                  errors++;
                  $display("FAIL stall_timeout lat=%0d actual=stuck required=release", LAT);
               end
               @(posedge clk); #2;
            end
         end
         drv_valid = 1'b0;
         ctlwb_in = 2'b00; branch = 1'b0; memread = 1'b0; memwrite = 1'b0;
         repeat (2) @(posedge clk);
         chk("queue_empty", LAT, 32'(q.size()), 32'd0);
         done = 1'b1;
      end

      always begin : mon
         logic samp_stall;
         exp_t e;
         @(negedge clk);
         if (drv_valid) begin
            samp_stall = stall;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL no_expectation lat=%0d actual=empty required=entry", LAT);
            end else begin
               chk("pcsrc",     LAT, 32'(pcsrc), 32'(q[0].pcs));
               chk("pc_target", LAT, pc_target, q[0].pct);
               @(posedge clk); #1;
               if (samp_stall) begin
                  stall_seen++;
                  chk("bubble_ctlwb", LAT, 32'(ctlwb_out), 32'd0);
                  chk("bubble_rdata", LAT, read_data_out, 32'd0);
                  chk("bubble_err",   LAT, 32'(mem_err), 32'd0);
                  chk("bubble_alu",   LAT, alu_result_out, q[0].alu);
               end else begin
                  e = q.pop_front();
                  chk("stall_cycles", LAT, 32'(stall_seen), 32'(e.nst));
                  chk("ctlwb_out",    LAT, 32'(ctlwb_out), 32'(e.ctl));
                  chk("read_data",    LAT, read_data_out, e.rd);
                  chk("alu_out",      LAT, alu_result_out, e.alu);
                  chk("dest_out",     LAT, 32'(dest_out), 32'(e.dest));
                  chk("mem_err",      LAT, 32'(mem_err), 32'(e.err));
                  $display("lat=%0d txn=%0d ctl=%b rdata=%h alu=%h dest=%0d err=%b stalls=%0d",
                           LAT, ntx, ctlwb_out, read_data_out, alu_result_out,
                           dest_out, mem_err, stall_seen);
                  stall_seen = 0;
                  ntx++;
               end
            end
         end
      end
   end

   initial begin : finish_ctl
      bit all_done;
      all_done = 1'b0;
      for (int c = 0; c < 20000 && !all_done; c++) begin
         @(posedge clk);
         all_done = g_lat[0].done && g_lat[1].done && g_lat[2].done;
      end
      if (!all_done) begin
         checks++;
         errors++;
         $display("FAIL run_timeout actual=unfinished required=all_done");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_mem_wb_stage
